// File: rtl/rr_request_encoder.sv
// Round-robin 4-to-2 request encoder feeding a 2-to-4 decoder (addr1:addr0 + enable).
// Define GRANT_TIMEOUT_EN to add a hold counter that forces release after MAX_HOLD grant cycles.
module rr_request_encoder #(
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in0,
  input  logic in1,
  input  logic in2,
  input  logic in3,
  output logic addr0,
  output logic addr1,
  output logic enable,
  output logic timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  if (MAX_HOLD < 2 || MAX_HOLD > (2 ** HOLD_W) - 1) begin : gBadParam
    $error("rr_request_encoder: MAX_HOLD out of range for HOLD_W");
  end

  state_t     state_q, state_d;
  logic [1:0] last_q, last_d;
  logic [1:0] addr_q, addr_d;
  logic       en_q, en_d;
  logic       timeout_q, timeout_d;
  logic [3:0] req;
  logic [1:0] pick;

`ifdef GRANT_TIMEOUT_EN
  logic [HOLD_W-1:0] hold_q, hold_d;
`endif

  assign req = {in3, in2, in1, in0};

  // Descending scan so the smallest offset from last (highest priority) is written last.
  function automatic logic [1:0] rrPick(input logic [3:0] r, input logic [1:0] l);
    logic [1:0] sel;
    logic [1:0] idx;
    sel = l;
    for (int i = 4; i >= 1; i--) begin
      idx = l + 2'(i);
      if (r[idx]) sel = idx;
    end
    return sel;
  endfunction

  assign pick = rrPick(req, last_q);

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    addr_d    = addr_q;
    en_d      = en_q;
    timeout_d = 1'b0;
`ifdef GRANT_TIMEOUT_EN
    hold_d    = hold_q;
`endif
    unique case (state_q)
      IDLE: begin
        en_d = 1'b0;
        if (|req) begin
          addr_d  = pick;
          last_d  = pick;
          en_d    = 1'b1;
          state_d = GRANT;
`ifdef GRANT_TIMEOUT_EN
          hold_d  = '0;
`endif
        end
      end
      GRANT: begin
        if (!req[last_q]) begin
          en_d    = 1'b0;
          state_d = IDLE;
`ifdef GRANT_TIMEOUT_EN
          hold_d  = '0;
`endif
        end else begin
`ifdef GRANT_TIMEOUT_EN
          // Normal release above wins over the limit; only a still-held request times out.
          if (hold_q == HOLD_W'(MAX_HOLD - 1)) begin
            en_d      = 1'b0;
            timeout_d = 1'b1;
            state_d   = IDLE;
            hold_d    = '0;
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
`endif
        end
      end
      default: begin
        state_d = IDLE;
        en_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      last_q    <= 2'd3;
      addr_q    <= 2'd0;
      en_q      <= 1'b0;
      timeout_q <= 1'b0;
`ifdef GRANT_TIMEOUT_EN
      hold_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      addr_q    <= addr_d;
      en_q      <= en_d;
      timeout_q <= timeout_d;
`ifdef GRANT_TIMEOUT_EN
      hold_q    <= hold_d;
`endif
    end
  end

  assign addr0   = addr_q[0];
  assign addr1   = addr_q[1];
  assign enable  = en_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_request_encoder.sv
// Directed bench for rr_request_encoder: reset, single request, round-robin order,
// reset mid-grant, and long-hold behaviour (timeout variant when GRANT_TIMEOUT_EN is defined).
module tb_rr_request_encoder;

  logic clk;
  logic rst_n;
  logic in0, in1, in2, in3;
  logic addr0, addr1, enable, timeout;

  int vectors    = 0;
  int miscompares = 0;

  rr_request_encoder #(.MAX_HOLD(8), .HOLD_W(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in0     (in0),
    .in1     (in1),
    .in2     (in2),
    .in3     (in3),
    .addr0   (addr0),
    .addr1   (addr1),
    .enable  (enable),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] r);
    {in3, in2, in1, in0} = r;
  endtask

  task automatic checkOutput(input string tag, input logic en, input logic [1:0] a, input logic to);
    vectors++;
    assert ({enable, addr1, addr0, timeout} === {en, a, to})
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed en=%b addr=%b%b to=%b, expected en=%b addr=%b to=%b",
             tag, enable, addr1, addr0, timeout, en, a, to);
    end
  endtask

  initial begin
    logic [3:0] allReq;
    allReq = 4'b1111;
    $display("[TB] start");

    // Reset with every request asserted, then first grant goes to in0.
    rst_n = 1'b0;
    applyStimulus(4'b1111);
    tick();
    checkOutput("reset_1", 1'b0, 2'b00, 1'b0);
    tick();
    checkOutput("reset_2", 1'b0, 2'b00, 1'b0);
    rst_n = 1'b1;
    tick();
    checkOutput("reset_release_grant0", 1'b1, 2'b00, 1'b0);
    applyStimulus(4'b0000);
    tick();
    checkOutput("reset_release_drop", 1'b0, 2'b00, 1'b0);
    tick();

    // Single request on in2 for five cycles.
    applyStimulus(4'b0100);
    tick();
    checkOutput("single_first", 1'b1, 2'b10, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("single_hold", 1'b1, 2'b10, 1'b0);
    end
    applyStimulus(4'b0000);
    tick();
    checkOutput("single_release", 1'b0, 2'b10, 1'b0);
    tick();
    checkOutput("single_idle_addr", 1'b0, 2'b10, 1'b0);

    // Round-robin from a fresh reset: 0,1,2,3,0 with a gap after each.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    applyStimulus(allReq);
    for (int i = 0; i < 5; i++) begin
      logic [1:0] g;
      logic [3:0] r;
      g = 2'(i % 4);
      tick();
      checkOutput("rr_grant", 1'b1, g, 1'b0);
      r = allReq;
      r[g] = 1'b0;
      applyStimulus(r);
      tick();
      checkOutput("rr_gap", 1'b0, g, 1'b0);
      applyStimulus(allReq);
    end

    // Reset in the middle of a grant to in1; in1 wins again since last returns to 3.
    applyStimulus(4'b0010);
    tick();
    checkOutput("midrst_grant1", 1'b1, 2'b01, 1'b0);
    rst_n = 1'b0;
    applyStimulus(4'b1010);
    tick();
    checkOutput("midrst_reset", 1'b0, 2'b00, 1'b0);
    rst_n = 1'b1;
    tick();
    checkOutput("midrst_regrant1", 1'b1, 2'b01, 1'b0);
    applyStimulus(4'b0000);
    tick();
    checkOutput("midrst_release", 1'b0, 2'b01, 1'b0);
    tick();

    // Long hold: in0 and in3 both requesting, in0 first after reset.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    applyStimulus(4'b1001);
    tick();
    checkOutput("hold_grant0", 1'b1, 2'b00, 1'b0);
    for (int i = 1; i < 8; i++) begin
      tick();
      checkOutput("hold_cycle", 1'b1, 2'b00, 1'b0);
    end
`ifdef GRANT_TIMEOUT_EN
    tick();
    checkOutput("timeout_pulse", 1'b0, 2'b00, 1'b1);
    tick();
    checkOutput("timeout_next_grant3", 1'b1, 2'b11, 1'b0);
    applyStimulus(4'b0000);
    tick();
    checkOutput("timeout_grant3_release", 1'b0, 2'b11, 1'b0);
    tick();

    // in0 drops in exactly the last allowed grant cycle: ordinary release.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    applyStimulus(4'b0001);
    tick();
    checkOutput("boundary_grant0", 1'b1, 2'b00, 1'b0);
    for (int i = 1; i < 8; i++) begin
      tick();
      checkOutput("boundary_hold", 1'b1, 2'b00, 1'b0);
    end
    applyStimulus(4'b0000);
    tick();
    checkOutput("boundary_release", 1'b0, 2'b00, 1'b0);
    tick();
    checkOutput("boundary_no_pulse", 1'b0, 2'b00, 1'b0);
`else
    for (int i = 0; i < 8; i++) begin
      tick();
      checkOutput("no_timeout_hold", 1'b1, 2'b00, 1'b0);
    end
    applyStimulus(4'b1000);
    tick();
    checkOutput("no_timeout_release", 1'b0, 2'b00, 1'b0);
    tick();
    checkOutput("no_timeout_grant3", 1'b1, 2'b11, 1'b0);
    applyStimulus(4'b0000);
    tick();
    checkOutput("no_timeout_grant3_release", 1'b0, 2'b11, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rr_request_encoder.md
Name: rr_request_encoder

Overview:
- Sequential 4-to-2 encoder: the transmit end of the 2-to-4 decoder interface (addr0, addr1, enable).
- Takes four request lines in0..in3, arbitrates round-robin, and drives a registered binary address plus enable into the decoder.
- The grant is held until the granted requester drops its request. The decoder's one-hot outputs then return the grant to the requester.

Parameters:
- MAX_HOLD, 8, maximum consecutive GRANT cycles before forced release (used only when GRANT_TIMEOUT_EN is defined); legal range 2..2^HOLD_W-1.
- HOLD_W, 4, width of the hold-cycle counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in0  input  1  request from requester 0.
- in1  input  1  request from requester 1.
- in2  input  1  request from requester 2.
- in3  input  1  request from requester 3.
- addr0  output  1  LSB of granted index, registered.
- addr1  output  1  MSB of granted index, registered.
- enable  output  1  grant valid, registered; connects to decoder enable.
- timeout  output  1  one-cycle pulse on forced release; constant 0 without GRANT_TIMEOUT_EN.

Behaviour:
- Reset:
  - rst_n sampled low at a clk rising edge sets addr0=0, addr1=0, enable=0, timeout=0, state=IDLE, last=3 (so in0 has first priority), hold counter=0.
  - Reset overrides any in-progress grant. Outputs are deasserted on the first edge rst_n is low.
- State IDLE:
  - enable=0.
  - If any inN=1, select the first asserted request searching last+1, last+2, last+3, last+4 (all mod 4).
  - Next edge: {addr1,addr0}=selected index, enable=1, last=selected, state=GRANT, counter=0.
  - If no request, stay in IDLE; addr0/addr1 hold their previous values.
- Latency: request sampled in IDLE at edge k gives enable=1 after edge k (one-cycle latency).
- State GRANT:
  - While in[last]=1, hold addr and enable=1. Requests from other requesters are ignored.
  - When in[last]=0 is sampled: next edge enable=0, state=IDLE. addr holds its value.
- Minimum gap: at least one enable=0 cycle between consecutive grants, even with back-to-back requests.
- Fairness: with all four requests continuously re-asserted, grants go 0,1,2,3,0,... The last pointer updates only on a new grant.
- Simultaneous events:
  - A request dropping and another rising in the same cycle in GRANT gives IDLE, then arbitration on the following cycle.
  - A request asserted and dropped within IDLE before sampling is lost; no latching.
- Decoder contract: enable changes only on clk edges; addr is stable whenever enable=1.
- Without GRANT_TIMEOUT_EN, the hold counter is not instantiated.

Optional Feature:
- Macro GRANT_TIMEOUT_EN.
- Defined:
  - In GRANT the counter increments each cycle that in[last]=1, saturating at MAX_HOLD-1.
  - When counter==MAX_HOLD-1 and in[last] is still 1: next edge enable=0, timeout=1 for exactly one cycle, state=IDLE, counter=0.
  - last stays at the released index, so a different waiting requester wins next.
  - If no other request is pending, the same requester is re-granted after the one-cycle gap.
  - A normal release takes precedence when in[last] drops in the same cycle the limit is reached; timeout stays 0.
- Undefined: a grant is held indefinitely; timeout is tied to 0.

Test Plan:
- Reset/idle: rst_n=0 for 2 cycles with in0..in3=1111, then rst_n=1 -> during reset addr=00, enable=0, timeout=0; enable=1 with addr=00 one edge after release.
- Single request: in2=1 for 5 cycles, then 0 -> enable=1 addr=10 for 5 cycles starting one edge after assertion; enable=0 one edge after the drop; addr stays 10.
- Round-robin: in0..in3 all held 1, each request dropped for one cycle after it is granted -> grant sequence addr 00,01,10,11,00, with an enable=0 gap between each.
- Reset mid-grant: in1 granted (enable=1, addr=01), rst_n=0 for one edge -> enable=0, addr=00; after release with in1, in3 still high -> in1 re-granted first (last reset to 3).
- Timeout (GRANT_TIMEOUT_EN, MAX_HOLD=8):
  - in0 and in3 held high -> in0 granted for 8 cycles, then enable=0 with a timeout pulse for 1 cycle, then in3 granted (addr=11).
  - Without the macro, in0 holds indefinitely and timeout stays 0.
- Boundary release (GRANT_TIMEOUT_EN): in0 dropped in exactly the 8th GRANT cycle -> normal release, timeout remains 0.
